// File: rtl/maze_timing_pkg.sv
// Shared timing constants and FSM encoding for the raycast maze frame pipeline.
package maze_timing_pkg;

    localparam int unsigned SYS_CLK_HZ = 50000000;
    localparam int unsigned FRAME_HZ   = 30;
    // Rounded to nearest: 50 MHz / 30 Hz = 1666666.67 -> 1666667.
    localparam int unsigned DEFAULT_TICK_CYCLES = (SYS_CLK_HZ + FRAME_HZ / 2) / FRAME_HZ;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_UPDATE = 2'd1;
    localparam state_t ST_RENDER = 2'd2;
    localparam state_t ST_SWAP   = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// Clock-enable frame tick generator: down-counter with reload and a registered one-cycle tick.
module tick_gen
    import maze_timing_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned CNT_W       = 21
) (
    input  logic clkin,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic             tick_q;

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            count_q <= RELOAD;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (enable) begin
                if (count_q == '0) begin
                    count_q <= RELOAD;
                    tick_q  <= 1'b1;
                end else begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/frame_scheduler.sv
// Frame-rate controller: sequences update, render and buffer swap per tick, queuing one late tick.
module frame_scheduler
    import maze_timing_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned FRAME_W     = 16,
    parameter int unsigned OVR_W       = 8
) (
    input  logic               clkin,
    input  logic               resetn,
    input  logic               enable,
    input  logic               update_done,
    input  logic               render_done,
    output logic               tick,
    output logic               update_start,
    output logic               render_start,
    output logic               swap,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_count,
    output logic [OVR_W-1:0]   overrun_count
);

    state_t             state_q, state_d;
    logic               pending_q;
    logic               update_start_q, render_start_q, swap_q, busy_q;
    logic [FRAME_W-1:0] frame_q;
    logic [OVR_W-1:0]   overrun_q;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES),
        .CNT_W      (CNT_W)
    ) u_tick_gen (
        .clkin (clkin),
        .resetn(resetn),
        .enable(enable),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tick || pending_q) state_d = ST_UPDATE;
            ST_UPDATE: if (update_done)       state_d = ST_RENDER;
            ST_RENDER: if (render_done)       state_d = ST_SWAP;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            update_start_q <= 1'b0;
            render_start_q <= 1'b0;
            swap_q         <= 1'b0;
            busy_q         <= 1'b0;
            frame_q        <= '0;
            overrun_q      <= '0;
        end else begin
            state_q        <= state_d;
            update_start_q <= (state_q == ST_IDLE)   && (state_d == ST_UPDATE);
            render_start_q <= (state_q == ST_UPDATE) && (state_d == ST_RENDER);
            swap_q         <= (state_q == ST_RENDER) && (state_d == ST_SWAP);
            busy_q         <= (state_d != ST_IDLE);
            if (state_q == ST_SWAP) begin
                frame_q <= frame_q + 1'b1;
            end
            // IDLE always consumes the queued tick; busy states queue one, then count drops.
            if (state_q == ST_IDLE) begin
                pending_q <= 1'b0;
            end else if (tick) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (overrun_q != '1) begin
                    overrun_q <= overrun_q + 1'b1;
                end
            end
        end
    end

    assign update_start  = update_start_q;
    assign render_start  = render_start_q;
    assign swap          = swap_q;
    assign busy          = busy_q;
    assign frame_count   = frame_q;
    assign overrun_count = overrun_q;

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Frame-rate controller for the raycast maze pipeline. A clock-enable tick generator on the 50 MHz system clock sets the frame rate; no derived clocks. Each tick starts one frame: the game-state update engine runs, then the raycast renderer, then a one-cycle buffer-swap strobe to the VGA side. Late engines are tolerated: one pending tick is queued, further ticks are counted as overruns.

## Interface
- TICK_CYCLES, 1666667, system cycles per frame tick (50 MHz / 30 Hz); legal range 2..2^CNT_W
- CNT_W, 21, tick counter width
- FRAME_W, 16, frame counter width
- OVR_W, 8, overrun counter width
- clkin  in  1  system clock, 50 MHz; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- enable  in  1  tick counter runs when 1; frames in flight always complete
- update_done  in  1  update engine finished; sampled only in UPDATE
- render_done  in  1  renderer finished; sampled only in RENDER
- tick  out  1  registered one-cycle frame-tick pulse
- update_start  out  1  one-cycle pulse: start game-state update
- render_start  out  1  one-cycle pulse: start raycast render
- swap  out  1  one-cycle pulse: swap frame buffers
- busy  out  1  1 whenever state != IDLE
- frame_count  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W
- overrun_count  out  OVR_W  dropped ticks, saturates at 2^OVR_W-1

## Operation
- Reset (resetn=0 at an edge): counter=TICK_CYCLES-1, state=IDLE, pending=0; tick, update_start, render_start, swap, busy=0; frame_count=0, overrun_count=0. Reset mid-frame aborts the frame; no swap issued.
- Tick generator: when enable=1, counter decrements; at 0 reloads TICK_CYCLES-1 and tick goes high the following cycle. enable=0 freezes counter; no ticks.
- FSM states IDLE, UPDATE, RENDER, SWAP:
  - IDLE -> UPDATE on tick=1 or pending=1; pending cleared.
  - UPDATE -> RENDER on update_done=1.
  - RENDER -> SWAP on render_done=1.
  - SWAP -> IDLE unconditionally; frame_count += 1 on that edge.
- Start/swap pulses are registered: update_start high exactly in the first UPDATE cycle, render_start in the first RENDER cycle, swap in the single SWAP cycle.
- done inputs are accepted in any cycle of their state, including the start-pulse cycle; done outside its state is ignored.
- Tick while state != IDLE: pending=0 -> pending=1; pending=1 -> tick dropped, overrun_count += 1 (saturating).
- Tick in the SWAP cycle: sets pending; IDLE in the next cycle then starts UPDATE.
- Tick in IDLE with pending=1 cannot occur (pending is consumed on the first IDLE cycle); the tick alone starts the frame.

## Timing
- First tick: high in cycle TICK_CYCLES after the reset-release edge, then every TICK_CYCLES enabled cycles.
- tick -> update_start: 1 cycle (tick seen in IDLE at edge N, update_start high after edge N).
- update_done -> render_start: 1 cycle; render_done -> swap: 1 cycle; swap -> IDLE: 1 cycle.
- Minimum frame length: 4 cycles (done pulses tied high); swap-to-next update_start with pending set: 2 cycles.
- busy is registered from state; goes high together with update_start, low the cycle after swap.

## Structure
- Package maze_timing_pkg: FSM state enum (2 bits), SYS_CLK_HZ=50000000, FRAME_HZ=30, default TICK_CYCLES derivation.
- Sub-module tick_gen (counter, enable, reload, registered tick; parameters TICK_CYCLES, CNT_W); the FSM, pending flag and counters stay in frame_scheduler.

## Test plan
- TICK_CYCLES=10, enable=1, done inputs tied high -> tick at cycles 10, 20, 30; each followed by update_start, render_start, swap on consecutive cycles; frame_count=3 after cycle 34.
- TICK_CYCLES=10, render_done delayed 25 cycles -> ticks at 20 and 30 arrive in RENDER: first sets pending, second gives overrun_count=1; after swap, update_start follows 2 cycles later.
- overrun_count preset path: hold render_done=0 for 300 ticks -> overrun_count stays at 255.
- enable=0 for 7 cycles mid-period -> next tick delayed by exactly 7 cycles; an in-flight frame still completes and swaps.
- resetn=0 for one edge during RENDER -> all outputs zero next cycle, no swap; next tick at TICK_CYCLES cycles after release.
- update_done/render_done pulsed in IDLE and in the wrong state -> no state change, no swap, frame_count unchanged.
